rf_write_arbiter: RTL and testbench

Write-port arbiter and scoreboard for the register file. Three writers share the single registered writeback port group (rd, pc, cpsr): the ALU writeback path, the load-return path and the trap unit. The block also keeps a 16-entry busy scoreboard that the execute stage uses for hazard stalls. It sits between those writers and the register file's `wb_*` inputs.

---
 rtl/rf_write_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_rf_write_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// Writeback arbiter for the register file: trap > round-robin(alu, ld) onto one
// registered wb_* port group, plus a 16-entry busy scoreboard for hazard stalls.
module rf_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int REG_N  = 16
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic              alu_rd_en,
    input  logic [3:0]        alu_rd_num,
    input  logic [DATA_W-1:0] alu_rd_data,
    input  logic              alu_pc_en,
    input  logic [DATA_W-1:0] alu_pc_data,
    input  logic              alu_cpsr_en,
    input  logic [DATA_W-1:0] alu_cpsr_data,

    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic              ld_rd_en,
    input  logic [3:0]        ld_rd_num,
    input  logic [DATA_W-1:0] ld_rd_data,
    input  logic              ld_pc_en,
    input  logic [DATA_W-1:0] ld_pc_data,
    input  logic              ld_cpsr_en,
    input  logic [DATA_W-1:0] ld_cpsr_data,

    input  logic              trap_valid,
    output logic              trap_ready,
    input  logic              trap_rd_en,
    input  logic [3:0]        trap_rd_num,
    input  logic [DATA_W-1:0] trap_rd_data,
    input  logic              trap_pc_en,
    input  logic [DATA_W-1:0] trap_pc_data,
    input  logic              trap_cpsr_en,
    input  logic [DATA_W-1:0] trap_cpsr_data,

    input  logic              iss_valid,
    input  logic [3:0]        iss_rd_num,
    output logic [REG_N-1:0]  busy_mask,
    output logic              flush,

    output logic              wb_rd_write_en,
    output logic [3:0]        wb_rd_num,
    output logic [DATA_W-1:0] wb_rd_in,
    output logic              wb_pc_write_en,
    output logic [DATA_W-1:0] wb_pc_in,
    output logic              wb_cpsr_write_en,
    output logic [DATA_W-1:0] wb_cpsr_in
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic               ptr_reg, ptr_next;
    logic [REG_N-1:0]   busy_reg, busy_next;

    logic               xfer;
    logic               sel_rd_en;
    logic [3:0]         sel_rd_num;
    logic [DATA_W-1:0]  sel_rd_data;
    logic               sel_pc_en;
    logic [DATA_W-1:0]  sel_pc_data;
    logic               sel_cpsr_en;
    logic [DATA_W-1:0]  sel_cpsr_data;
    logic               flush_clr;

    // Grants: trap always wins; alu/ld only in RUN and only when no trap pending.
    always_comb begin
        alu_ready  = 1'b0;
        ld_ready   = 1'b0;
        trap_ready = 1'b0;
        if (reset) begin
            trap_ready = trap_valid;
            if (state_reg == ST_RUN && !trap_valid) begin
                if (alu_valid && (!ptr_reg || !ld_valid)) begin
                    alu_ready = 1'b1;
                end else if (ld_valid) begin
                    ld_ready = 1'b1;
                end
            end
        end
    end

    assign xfer = alu_ready | ld_ready | trap_ready;

    always_comb begin
        sel_rd_en     = 1'b0;
        sel_rd_num    = '0;
        sel_rd_data   = '0;
        sel_pc_en     = 1'b0;
        sel_pc_data   = '0;
        sel_cpsr_en   = 1'b0;
        sel_cpsr_data = '0;
        if (trap_ready) begin
            sel_rd_en     = trap_rd_en;
            sel_rd_num    = trap_rd_num;
            sel_rd_data   = trap_rd_data;
            sel_pc_en     = trap_pc_en;
            sel_pc_data   = trap_pc_data;
            sel_cpsr_en   = trap_cpsr_en;
            sel_cpsr_data = trap_cpsr_data;
        end else if (alu_ready) begin
            sel_rd_en     = alu_rd_en;
            sel_rd_num    = alu_rd_num;
            sel_rd_data   = alu_rd_data;
            sel_pc_en     = alu_pc_en;
            sel_pc_data   = alu_pc_data;
            sel_cpsr_en   = alu_cpsr_en;
            sel_cpsr_data = alu_cpsr_data;
        end else if (ld_ready) begin
            sel_rd_en     = ld_rd_en;
            sel_rd_num    = ld_rd_num;
            sel_rd_data   = ld_rd_data;
            sel_pc_en     = ld_pc_en;
            sel_pc_data   = ld_pc_data;
            sel_cpsr_en   = ld_cpsr_en;
            sel_cpsr_data = ld_cpsr_data;
        end
    end

    always_comb begin
        state_next = ST_RUN;
        ptr_next   = ptr_reg;
        if (trap_ready) begin
            state_next = ST_FLUSH;
        end
        if (alu_ready) begin
            ptr_next = 1'b1;
        end else if (ld_ready) begin
            ptr_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_RUN;
            ptr_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
        end
    end

    // Clearing on the trap edge keeps busy_mask at 0 throughout the FLUSH cycle;
    // issues seen during FLUSH belong to squashed instructions and are dropped.
    assign flush_clr = trap_ready | (state_reg == ST_FLUSH);

    generate
        for (genvar gi = 0; gi < REG_N; gi++) begin : g_busy
            logic set_bit, clr_bit;
            assign set_bit = iss_valid && (iss_rd_num == 4'(gi));
            assign clr_bit = xfer && sel_rd_en && (sel_rd_num == 4'(gi));
            always_comb begin
                busy_next[gi] = busy_reg[gi];
                if (flush_clr) begin
                    busy_next[gi] = 1'b0;
                end else if (set_bit) begin
                    busy_next[gi] = 1'b1;
                end else if (clr_bit) begin
                    busy_next[gi] = 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    assign busy_mask = busy_reg;
    assign flush     = (state_reg == ST_FLUSH);

    // Data registers load only with their enable so the register file sees stable values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_rd_write_en   <= 1'b0;
            wb_rd_num        <= '0;
            wb_rd_in         <= '0;
            wb_pc_write_en   <= 1'b0;
            wb_pc_in         <= '0;
            wb_cpsr_write_en <= 1'b0;
            wb_cpsr_in       <= '0;
        end else begin
            wb_rd_write_en   <= xfer & sel_rd_en;
            wb_pc_write_en   <= xfer & sel_pc_en;
            wb_cpsr_write_en <= xfer & sel_cpsr_en;
            if (xfer && sel_rd_en) begin
                wb_rd_num <= sel_rd_num;
                wb_rd_in  <= sel_rd_data;
            end
            if (xfer && sel_pc_en) begin
                wb_pc_in <= sel_pc_data;
            end
            if (xfer && sel_cpsr_en) begin
                wb_cpsr_in <= sel_cpsr_data;
            end
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: reset, single write, round-robin, trap
// preemption and back-to-back traps, scoreboard race and null transfer.
module tb_rf_write_arbiter;

    localparam int DATA_W = 32;
    localparam int REG_N  = 16;

    logic              clk;
    logic              reset;
    logic              alu_valid, alu_ready, alu_rd_en, alu_pc_en, alu_cpsr_en;
    logic [3:0]        alu_rd_num;
    logic [DATA_W-1:0] alu_rd_data, alu_pc_data, alu_cpsr_data;
    logic              ld_valid, ld_ready, ld_rd_en, ld_pc_en, ld_cpsr_en;
    logic [3:0]        ld_rd_num;
    logic [DATA_W-1:0] ld_rd_data, ld_pc_data, ld_cpsr_data;
    logic              trap_valid, trap_ready, trap_rd_en, trap_pc_en, trap_cpsr_en;
    logic [3:0]        trap_rd_num;
    logic [DATA_W-1:0] trap_rd_data, trap_pc_data, trap_cpsr_data;
    logic              iss_valid;
    logic [3:0]        iss_rd_num;
    logic [REG_N-1:0]  busy_mask;
    logic              flush;
    logic              wb_rd_write_en, wb_pc_write_en, wb_cpsr_write_en;
    logic [3:0]        wb_rd_num;
    logic [DATA_W-1:0] wb_rd_in, wb_pc_in, wb_cpsr_in;

    int tests_run    = 0;
    int tests_failed = 0;

    rf_write_arbiter #(.DATA_W(DATA_W), .REG_N(REG_N)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd_en(alu_rd_en),
        .alu_rd_num(alu_rd_num), .alu_rd_data(alu_rd_data), .alu_pc_en(alu_pc_en),
        .alu_pc_data(alu_pc_data), .alu_cpsr_en(alu_cpsr_en), .alu_cpsr_data(alu_cpsr_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd_en(ld_rd_en),
        .ld_rd_num(ld_rd_num), .ld_rd_data(ld_rd_data), .ld_pc_en(ld_pc_en),
        .ld_pc_data(ld_pc_data), .ld_cpsr_en(ld_cpsr_en), .ld_cpsr_data(ld_cpsr_data),
        .trap_valid(trap_valid), .trap_ready(trap_ready), .trap_rd_en(trap_rd_en),
        .trap_rd_num(trap_rd_num), .trap_rd_data(trap_rd_data), .trap_pc_en(trap_pc_en),
        .trap_pc_data(trap_pc_data), .trap_cpsr_en(trap_cpsr_en), .trap_cpsr_data(trap_cpsr_data),
        .iss_valid(iss_valid), .iss_rd_num(iss_rd_num),
        .busy_mask(busy_mask), .flush(flush),
        .wb_rd_write_en(wb_rd_write_en), .wb_rd_num(wb_rd_num), .wb_rd_in(wb_rd_in),
        .wb_pc_write_en(wb_pc_write_en), .wb_pc_in(wb_pc_in),
        .wb_cpsr_write_en(wb_cpsr_write_en), .wb_cpsr_in(wb_cpsr_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", tag, got);
        end
    endtask

    // Step to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        alu_valid = 0; alu_rd_en = 0; alu_rd_num = 0; alu_rd_data = 0;
        alu_pc_en = 0; alu_pc_data = 0; alu_cpsr_en = 0; alu_cpsr_data = 0;
        ld_valid = 0; ld_rd_en = 0; ld_rd_num = 0; ld_rd_data = 0;
        ld_pc_en = 0; ld_pc_data = 0; ld_cpsr_en = 0; ld_cpsr_data = 0;
        trap_valid = 0; trap_rd_en = 0; trap_rd_num = 0; trap_rd_data = 0;
        trap_pc_en = 0; trap_pc_data = 0; trap_cpsr_en = 0; trap_cpsr_data = 0;
        iss_valid = 0; iss_rd_num = 0;

        // Reset: alu pending rd=5 while reset held, then a write dropped in flight.
        alu_valid = 1; alu_rd_en = 1; alu_rd_num = 4'd5; alu_rd_data = 32'h5555_0005;
        tick(); tick();
        check("rst_alu_ready", alu_ready, 0);
        check("rst_busy", busy_mask, 0);
        check("rst_wb_rd_en", wb_rd_write_en, 0);
        check("rst_flush", flush, 0);
        reset = 1'b1;
        #1;
        check("rel_alu_ready", alu_ready, 1);
        tick();
        check("pre_rst_wb_rd_en", wb_rd_write_en, 1);
        reset = 1'b0;
        #1;
        check("inflight_wb_rd_en", wb_rd_write_en, 0);
        check("inflight_wb_rd_num", wb_rd_num, 0);
        check("inflight_wb_rd_in", wb_rd_in, 0);
        check("inflight_alu_ready", alu_ready, 0);
        alu_valid = 0;
        tick();
        reset = 1'b1;
        tick();

        // Single ALU write after issue of rd=3.
        iss_valid = 1; iss_rd_num = 4'd3;
        tick();
        iss_valid = 0;
        check("issue_busy", busy_mask, 16'h0008);
        alu_valid = 1; alu_rd_en = 1; alu_rd_num = 4'd3; alu_rd_data = 32'hDEAD_BEEF;
        #1;
        check("single_alu_ready", alu_ready, 1);
        tick();
        alu_valid = 0;
        check("single_wb_rd_en", wb_rd_write_en, 1);
        check("single_wb_rd_num", wb_rd_num, 3);
        check("single_wb_rd_in", wb_rd_in, 32'hDEAD_BEEF);
        check("single_busy", busy_mask, 0);

        // Reset pulse so the round-robin pointer starts at alu.
        reset = 1'b0;
        #2;
        reset = 1'b1;
        tick();

        // Round-robin: alu rd=1, ld rd=2, both valid for 4 cycles.
        alu_valid = 1; alu_rd_en = 1; alu_rd_num = 4'd1; alu_rd_data = 32'hA1;
        ld_valid  = 1; ld_rd_en  = 1; ld_rd_num  = 4'd2; ld_rd_data  = 32'hB2;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("rr%0d_alu_ready", i), alu_ready, (i % 2 == 0) ? 1 : 0);
            check($sformatf("rr%0d_ld_ready", i), ld_ready, (i % 2 == 1) ? 1 : 0);
            tick();
            check($sformatf("rr%0d_wb_rd_num", i), wb_rd_num, (i % 2 == 0) ? 1 : 2);
        end

        // Trap preemption with busy bit 9 outstanding.
        alu_valid = 0; ld_valid = 0;
        iss_valid = 1; iss_rd_num = 4'd9;
        tick();
        iss_valid = 0;
        check("pre_trap_busy", busy_mask, 16'h0200);
        alu_valid = 1; ld_valid = 1;
        trap_valid = 1; trap_pc_en = 1; trap_pc_data = 32'h0000_0008;
        trap_cpsr_en = 1; trap_cpsr_data = 32'h0000_001F;
        #1;
        check("trap_ready", trap_ready, 1);
        check("trap_alu_ready", alu_ready, 0);
        check("trap_ld_ready", ld_ready, 0);
        tick();
        trap_valid = 0;
        #1;
        check("trap_wb_pc_en", wb_pc_write_en, 1);
        check("trap_wb_pc_in", wb_pc_in, 32'h8);
        check("trap_wb_cpsr_in", wb_cpsr_in, 32'h1F);
        check("trap_wb_rd_en", wb_rd_write_en, 0);
        check("trap_flush", flush, 1);
        check("trap_busy", busy_mask, 0);
        check("flush_alu_ready", alu_ready, 0);
        check("flush_ld_ready", ld_ready, 0);
        tick();
        check("post_flush", flush, 0);
        check("post_flush_alu_ready", alu_ready, 1);
        tick();
        check("post_flush_wb_rd_num", wb_rd_num, 1);
        check("post_flush_ld_ready", ld_ready, 1);
        tick();
        alu_valid = 0; ld_valid = 0;
        check("post_flush_ld_wb", wb_rd_num, 2);

        // Scoreboard race: issue rd=7 and ld write rd=7 in the same cycle.
        iss_valid = 1; iss_rd_num = 4'd7;
        ld_valid = 1; ld_rd_en = 1; ld_rd_num = 4'd7; ld_rd_data = 32'h0000_0777;
        #1;
        check("race_ld_ready", ld_ready, 1);
        tick();
        iss_valid = 0; ld_valid = 0;
        check("race_busy", busy_mask, 16'h0080);
        check("race_wb_rd_num", wb_rd_num, 7);
        alu_valid = 1; alu_rd_en = 1; alu_rd_num = 4'd7; alu_rd_data = 32'h7070_7070;
        tick();
        alu_valid = 0;
        check("race_clear_busy", busy_mask, 0);
        check("race_clear_wb_rd_in", wb_rd_in, 32'h7070_7070);

        // Null transfer from ld (pointer currently at ld).
        ld_valid = 1; ld_rd_en = 0; ld_pc_en = 0; ld_cpsr_en = 0;
        #1;
        check("null_ld_ready", ld_ready, 1);
        tick();
        ld_valid = 0;
        check("null_wb_rd_en", wb_rd_write_en, 0);
        check("null_wb_pc_en", wb_pc_write_en, 0);
        check("null_wb_cpsr_en", wb_cpsr_write_en, 0);
        check("null_wb_rd_in_hold", wb_rd_in, 32'h7070_7070);
        alu_valid = 1; alu_rd_num = 4'd4; alu_rd_en = 1; alu_rd_data = 32'h44;
        ld_valid = 1; ld_rd_en = 1;
        #1;
        check("null_ptr_alu_ready", alu_ready, 1);
        check("null_ptr_ld_ready", ld_ready, 0);
        tick();
        ld_valid = 0;

        // Back-to-back traps: second trap accepted during FLUSH extends it.
        trap_valid = 1; trap_pc_data = 32'h0000_000C;
        #1;
        check("t2_first_ready", trap_ready, 1);
        tick();
        check("t2_flush1", flush, 1);
        check("t2_second_ready", trap_ready, 1);
        check("t2_alu_blocked1", alu_ready, 0);
        tick();
        trap_valid = 0;
        #1;
        check("t2_flush2", flush, 1);
        check("t2_alu_blocked2", alu_ready, 0);
        tick();
        check("t2_run", flush, 0);
        check("t2_alu_ready", alu_ready, 1);
        tick();
        alu_valid = 0;
        check("t2_wb_rd_num", wb_rd_num, 4);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
